imem_loader: RTL and testbench

Parametrised instruction memory with an integrated byte-stream programming port, replacing the fixed 16-bit ROM-plus-loader. A byte source such as the UART receiver streams bytes in while `load_en` is high. The block packs them into `DW`-bit words of selectable byte order and writes them from a programmable base address. It also keeps a running checksum and reports overflow. When not loading, it serves the CPU fetch stage through a synchronous read port.

---
 rtl/imem_loader.sv | 194 +++++++++++++++++++
 tb/tb_imem_loader.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Instruction memory with a byte-stream programming port. While load_en is
// high, incoming bytes are packed into DW-bit words (byte order chosen by
// BIG_ENDIAN) and written from a programmable base address. The block keeps a
// mod-256 checksum of accepted bytes and flags overflow. When no session is
// active it serves the fetch stage through a registered read port.
//
// Ports
//   clk         in   1     system clock, rising edge
//   rst_n       in   1     asynchronous active-low reset
//   addr        in   AW    fetch word address
//   rdata       out  DW    fetch data, registered (1-cycle latency)
//   load_en     in   1     level; rising edge starts, falling edge ends a session
//   load_base   in   AW    start word address, sampled on load_en rising edge
//   byte_valid  in   1     byte_data is valid
//   byte_data   in   8     programming byte
//   byte_ready  out  1     byte accepted this cycle if byte_valid
//   load_busy   out  1     session active (LOAD or FLUSH)
//   load_full   out  1     write pointer has reached DEPTH
//   load_ovf    out  1     sticky: a byte was offered while full
//   word_cnt    out  AW+1  words written this session
//   checksum    out  8     mod-256 sum of accepted bytes this session
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int    DW         = 16,
   parameter int    AW         = 16,
   parameter int    DEPTH      = 4096,
   parameter bit    BIG_ENDIAN = 1'b1,
   parameter string INIT_FILE  = ""
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] addr,
   output logic [DW-1:0] rdata,
   input  logic          load_en,
   input  logic [AW-1:0] load_base,
   input  logic          byte_valid,
   input  logic [7:0]    byte_data,
   output logic          byte_ready,
   output logic          load_busy,
   output logic          load_full,
   output logic          load_ovf,
   output logic [AW:0]   word_cnt,
   output logic [7:0]    checksum
);

   localparam int NB = DW / 8;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH} state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic            r_load_en_d;
   logic [AW:0]     r_wptr;
   logic [BW-1:0]   r_idx;
   logic [DW-1:0]   r_buf;
   logic [AW:0]     r_word_cnt;
   logic [7:0]      r_checksum;
   logic            r_ovf;
   logic [DW-1:0]   r_rdata;
   logic [DW-1:0]   r_mem [DEPTH];

   logic            w_start;
   logic            w_full;
   logic            w_accept;
   logic            w_last;
   logic [BW-1:0]   w_lane;
   logic [DW-1:0]   w_buf_next;
   logic            w_wr_en;
   logic [DW-1:0]   w_wr_data;
   logic [DW-1:0]   w_fetch;

   assign w_start  = load_en & ~r_load_en_d;
   assign w_full   = (r_wptr == DEPTH_W);
   // Acceptance is gated by the current load_en so the cycle in which the
   // falling edge is seen never takes a byte.
   assign w_accept = (r_state == S_LOAD) & load_en & byte_valid & ~w_full;
   assign w_last   = (r_idx == BW'(NB-1));
   assign w_lane   = BIG_ENDIAN ? (BW'(NB-1) - r_idx) : r_idx;

   // Out-of-range fetch addresses read as zero instead of aliasing.
   assign w_fetch  = ({1'b0, addr} < DEPTH_W) ? r_mem[addr[IW-1:0]] : '0;

   // Buffered bytes plus the incoming byte, so the last byte of a word is
   // written on the same edge that accepts it.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      w_buf_next = r_buf;
      w_buf_next[w_lane*8 +: 8] = byte_data;
   end

   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_data = w_buf_next;
      if (r_state == S_LOAD && w_accept && w_last) begin
         w_wr_en = 1'b1;
      end else if (r_state == S_FLUSH) begin
         w_wr_en   = 1'b1;
         w_wr_data = r_buf;      // unreceived lanes are still zero
      end
   end

   // Next-state and FSM outputs.
   always_comb begin
      w_state_next = r_state;
      byte_ready   = 1'b0;
      load_busy    = (r_state != S_IDLE);
      case (r_state)
         S_IDLE:  if (w_start) w_state_next = S_LOAD;
         S_LOAD: begin
            byte_ready = load_en & ~w_full;
            if (!load_en) w_state_next = (r_idx != '0) ? S_FLUSH : S_IDLE;
         end
         S_FLUSH: w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_load_en_d <= 1'b0;
         r_wptr      <= '0;
         r_idx       <= '0;
         r_buf       <= '0;
         r_word_cnt  <= '0;
         r_checksum  <= '0;
         r_ovf       <= 1'b0;
         r_rdata     <= '0;
      end else begin
         r_load_en_d <= load_en;
         case (r_state)
            S_IDLE: begin
               r_rdata <= w_fetch;
               if (w_start) begin
                  r_wptr     <= {1'b0, load_base};
                  r_idx      <= '0;
                  r_buf      <= '0;
                  r_word_cnt <= '0;
                  r_checksum <= '0;
                  r_ovf      <= 1'b0;
               end
            end
            S_LOAD: begin
               if (load_en && byte_valid && w_full) r_ovf <= 1'b1;
               if (w_accept) begin
                  r_checksum <= r_checksum + byte_data;
                  if (w_last) begin
                     r_idx      <= '0;
                     r_buf      <= '0;
                     r_wptr     <= r_wptr + (AW+1)'(1);
                     r_word_cnt <= r_word_cnt + (AW+1)'(1);
                  end else begin
                     r_idx <= r_idx + BW'(1);
                     r_buf <= w_buf_next;
                  end
               end
            end
            S_FLUSH: begin
               r_idx      <= '0;
               r_buf      <= '0;
               r_wptr     <= r_wptr + (AW+1)'(1);
               r_word_cnt <= r_word_cnt + (AW+1)'(1);
            end
            default: ;
         endcase
      end
   end

   // NOTE: the memory array has no reset; its contents survive rst_n and it
   // maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (w_wr_en && (r_wptr < DEPTH_W)) r_mem[r_wptr[IW-1:0]] <= w_wr_data;
   end

   assign rdata     = r_rdata;
   assign load_full = w_full;
   assign load_ovf  = r_ovf;
   assign word_cnt  = r_word_cnt;
   assign checksum  = r_checksum;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Four instances share the byte/address inputs, each with its own load_en:
//   u0  DW=16 big-endian, DEPTH=4096  (tracked every cycle by a queue model)
//   u1  DW=32 little-endian
//   u2  DW=16 big-endian, DEPTH=4     (full / overflow)
//   u3  DW=64 little-endian           (sustained streaming)
// -----------------------------------------------------------------------------
module tb_imem_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [15:0] addr, load_base;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic [3:0]  en;

   logic [15:0] rd0, rd2;
   logic [31:0] rd1;
   logic [63:0] rd3;
   logic        rdy [4];
   logic        busy[4];
   logic        full[4];
   logic        ovf [4];
   logic [16:0] wc  [4];
   logic [7:0]  cs  [4];

   int n_tests = 0;
   int n_fail  = 0;
   bit live    = 1'b0;

   imem_loader #(.DW(16), .AW(16), .DEPTH(4096), .BIG_ENDIAN(1'b1)) u0 (
      .clk(clk), .rst_n(rst_n), .addr(addr), .rdata(rd0), .load_en(en[0]),
      .load_base(load_base), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(rdy[0]), .load_busy(busy[0]), .load_full(full[0]),
      .load_ovf(ovf[0]), .word_cnt(wc[0]), .checksum(cs[0]));

   imem_loader #(.DW(32), .AW(16), .DEPTH(4096), .BIG_ENDIAN(1'b0)) u1 (
      .clk(clk), .rst_n(rst_n), .addr(addr), .rdata(rd1), .load_en(en[1]),
      .load_base(load_base), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(rdy[1]), .load_busy(busy[1]), .load_full(full[1]),
      .load_ovf(ovf[1]), .word_cnt(wc[1]), .checksum(cs[1]));

   imem_loader #(.DW(16), .AW(16), .DEPTH(4), .BIG_ENDIAN(1'b1)) u2 (
      .clk(clk), .rst_n(rst_n), .addr(addr), .rdata(rd2), .load_en(en[2]),
      .load_base(load_base), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(rdy[2]), .load_busy(busy[2]), .load_full(full[2]),
      .load_ovf(ovf[2]), .word_cnt(wc[2]), .checksum(cs[2]));

   imem_loader #(.DW(64), .AW(16), .DEPTH(4096), .BIG_ENDIAN(1'b0)) u3 (
      .clk(clk), .rst_n(rst_n), .addr(addr), .rdata(rd3), .load_en(en[3]),
      .load_base(load_base), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(rdy[3]), .load_busy(busy[3]), .load_full(full[3]),
      .load_ovf(ovf[3]), .word_cnt(wc[3]), .checksum(cs[3]));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] rdval(input int k);
      case (k)
         0:       return {48'h0, rd0};
         1:       return {32'h0, rd1};
         2:       return {48'h0, rd2};
         default: return rd3;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_chk(input int k, input logic [15:0] a, input logic [63:0] exp,
                           input string name);
      addr = a;
      tick();
      check(name, rdval(k), exp);
   endtask

   // Open a session, stream n bytes (first byte in the top of bs), then drop
   // load_en and let one edge sample it low. addr wanders while loading.
   task automatic run_session(input int k, input logic [15:0] base,
                              input logic [63:0] bs, input int n);
      load_base = base;
      en[k]     = 1'b1;
      tick();
      for (int i = 0; i < n; i++) begin
         byte_valid = 1'b1;
         byte_data  = bs[8*(n-1-i) +: 8];
         addr       = 16'(i * 3 + 1);
         tick();
      end
      byte_valid = 1'b0;
      en[k]      = 1'b0;
      tick();
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model of u0: written words live in an associative array,
   // the partial word is a byte queue.
   // ---------------------------------------------------------------------
   typedef enum {M_IDLE, M_LOAD, M_FLUSH} mphase_t;
   logic [15:0] m_mem [int];
   logic [7:0]  m_q[$];
   mphase_t     m_phase;
   bit          m_prev_en;
   int          m_wptr;
   int          m_cnt;
   logic [7:0]  m_sum;
   bit          m_ovf;
   logic [15:0] m_rdata;
   bit          m_rd_known;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = M_IDLE; m_prev_en = 1'b0; m_wptr = 0; m_cnt = 0;
         m_sum = 8'h00; m_ovf = 1'b0; m_rdata = 16'h0; m_rd_known = 1'b1;
         m_q.delete();
      end else begin
         case (m_phase)
            M_IDLE: begin
               if (int'(addr) >= 4096) begin
                  m_rdata = 16'h0; m_rd_known = 1'b1;
               end else if (m_mem.exists(int'(addr))) begin
                  m_rdata = m_mem[int'(addr)]; m_rd_known = 1'b1;
               end else begin
                  m_rd_known = 1'b0;
               end
               if (en[0] && !m_prev_en) begin
                  m_phase = M_LOAD; m_wptr = int'(load_base);
                  m_cnt = 0; m_sum = 8'h00; m_ovf = 1'b0; m_q.delete();
               end
            end
            M_LOAD: begin
               if (!en[0]) begin
                  m_phase = (m_q.size() != 0) ? M_FLUSH : M_IDLE;
               end else if (byte_valid) begin
                  if (m_wptr == 4096) m_ovf = 1'b1;
                  else begin
                     m_q.push_back(byte_data);
                     m_sum = m_sum + byte_data;
                     if (m_q.size() == 2) begin
                        m_mem[m_wptr] = {m_q[0], m_q[1]};
                        m_wptr++; m_cnt++; m_q.delete();
                     end
                  end
               end
            end
            M_FLUSH: begin
               m_mem[m_wptr] = {m_q[0], 8'h00};
               m_wptr++; m_cnt++; m_q.delete();
               m_phase = M_IDLE;
            end
            default: m_phase = M_IDLE;
         endcase
         m_prev_en = en[0];
      end
   end

   // Compare u0 against the model on every falling edge once out of reset.
   always @(negedge clk) begin
      if (live) begin
         check("u0_ready", 64'(rdy[0]),
               64'((m_phase == M_LOAD) && en[0] && (m_wptr != 4096)));
         check("u0_busy",  64'(busy[0]), 64'(m_phase != M_IDLE));
         check("u0_full",  64'(full[0]), 64'(m_wptr == 4096));
         check("u0_ovf",   64'(ovf[0]),  64'(m_ovf));
         check("u0_wcnt",  64'(wc[0]),   64'(m_cnt));
         check("u0_csum",  64'(cs[0]),   64'(m_sum));
         if (m_rd_known) check("u0_rdata", 64'(rd0), 64'(m_rdata));
      end
   end

   // ---------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------
   initial begin
      logic [63:0] held;
      logic [63:0] w_exp;
      logic [7:0]  b;
      logic [7:0]  sw_sum;

      rst_n = 1'b0; en = 4'h0; byte_valid = 1'b0; byte_data = 8'h00;
      addr = 16'h0; load_base = 16'h0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      live = 1'b1;

      for (int k = 0; k < 4; k++) begin
         check("rst_rdata", rdval(k), 64'h0);
         check("rst_ready", 64'(rdy[k]),  64'h0);
         check("rst_busy",  64'(busy[k]), 64'h0);
         check("rst_full",  64'(full[k]), 64'h0);
         check("rst_ovf",   64'(ovf[k]),  64'h0);
         check("rst_wcnt",  64'(wc[k]),   64'h0);
         check("rst_csum",  64'(cs[k]),   64'h0);
      end

      // 16-bit big-endian words.
      run_session(0, 16'h0000, 64'h12345678, 4);
      check("t1_busy", 64'(busy[0]), 64'h0);
      check("t1_wcnt", 64'(wc[0]),   64'd2);
      check("t1_csum", 64'(cs[0]),   64'h14);
      read_chk(0, 16'h0001, 64'h5678, "t1_mem1");
      read_chk(0, 16'h0000, 64'h1234, "t1_mem0");

      // Odd byte count -> FLUSH; rdata held while addr moves during LOAD.
      held = rdval(0);
      run_session(0, 16'h0100, 64'hA1B2C3D4E5, 5);
      check("t6_flush_busy", 64'(busy[0]), 64'h1);
      check("t6_rd_held",    rdval(0),     held);
      tick();
      check("t6_idle_busy", 64'(busy[0]), 64'h0);
      check("t6_wcnt",      64'(wc[0]),   64'd3);
      check("t6_csum",      64'(cs[0]),   64'hCF);
      addr = 16'h0102;
      check("t6_lat_before", rdval(0), held);
      tick();
      check("t6_lat_after", rdval(0), 64'hE500);
      read_chk(0, 16'h0100, 64'hA1B2, "t6_mem100");
      read_chk(0, 16'h0101, 64'hC3D4, "t6_mem101");

      // Reset in the middle of a word.
      run_session(0, 16'h0020, 64'h1111, 2);
      load_base = 16'h0020; en[0] = 1'b1;
      tick();
      byte_valid = 1'b1; byte_data = 8'h9A;
      tick();
      byte_valid = 1'b0;
      #2 rst_n = 1'b0; en[0] = 1'b0;
      #1;
      check("t4_rdata", rdval(0),        64'h0);
      check("t4_ready", 64'(rdy[0]),     64'h0);
      check("t4_busy",  64'(busy[0]),    64'h0);
      check("t4_full",  64'(full[0]),    64'h0);
      check("t4_ovf",   64'(ovf[0]),     64'h0);
      check("t4_wcnt",  64'(wc[0]),      64'h0);
      check("t4_csum",  64'(cs[0]),      64'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      read_chk(0, 16'h0020, 64'h1111, "t4_kept");
      run_session(0, 16'h0020, 64'h5566, 2);
      check("t4_wcnt2", 64'(wc[0]), 64'd1);
      check("t4_csum2", 64'(cs[0]), 64'hBB);
      read_chk(0, 16'h0020, 64'h5566, "t4_new");

      // 32-bit little-endian, partial word.
      run_session(1, 16'h0010, 64'hAABBCC, 3);
      check("t2_flush_busy", 64'(busy[1]), 64'h1);
      tick();
      check("t2_idle_busy", 64'(busy[1]), 64'h0);
      check("t2_wcnt",      64'(wc[1]),   64'd1);
      check("t2_csum",      64'(cs[1]),   64'h31);
      read_chk(1, 16'h0010, 64'h00CCBBAA, "t2_mem10");

      // DEPTH=4 from base 2: full after 4 bytes, later bytes dropped.
      load_base = 16'h0002; en[2] = 1'b1;
      tick();
      for (int i = 1; i <= 6; i++) begin
         byte_valid = 1'b1; byte_data = 8'(i);
         tick();
         if (i == 3) check("t3_not_full", 64'(full[2]), 64'h0);
         if (i == 4) begin
            check("t3_full",     64'(full[2]), 64'h1);
            check("t3_ready0",   64'(rdy[2]),  64'h0);
            check("t3_ovf_pre",  64'(ovf[2]),  64'h0);
         end
      end
      byte_valid = 1'b0;
      check("t3_ovf",  64'(ovf[2]), 64'h1);
      check("t3_csum", 64'(cs[2]),  64'h0A);
      check("t3_wcnt", 64'(wc[2]),  64'd2);
      en[2] = 1'b0;
      tick();
      check("t3_busy",      64'(busy[2]), 64'h0);
      check("t3_full_hold", 64'(full[2]), 64'h1);
      check("t3_ovf_hold",  64'(ovf[2]),  64'h1);
      read_chk(2, 16'h0002, 64'h0102, "t3_mem2");
      read_chk(2, 16'h0003, 64'h0304, "t3_mem3");
      read_chk(2, 16'h0005, 64'h0000, "t3_oob");

      // 256 back-to-back bytes into 64-bit words.
      sw_sum = 8'h00;
      load_base = 16'h0000; en[3] = 1'b1;
      tick();
      for (int i = 0; i < 256; i++) begin
         b = 8'(i * 7 + 3);
         byte_valid = 1'b1; byte_data = b;
         sw_sum = sw_sum + b;
         check("t5_ready", 64'(rdy[3]), 64'h1);
         tick();
      end
      byte_valid = 1'b0; en[3] = 1'b0;
      tick();
      check("t5_busy",     64'(busy[3]), 64'h0);
      check("t5_wcnt",     64'(wc[3]),   64'd32);
      check("t5_csum",     64'(cs[3]),   64'(sw_sum));
      check("t5_csum_lit", 64'(cs[3]),   64'h80);
      read_chk(3, 16'h0000, 64'h342D261F18110A03, "t5_word0");
      for (int w = 5; w <= 31; w += 26) begin
         for (int j = 0; j < 8; j++) w_exp[j*8 +: 8] = 8'((w * 8 + j) * 7 + 3);
         read_chk(3, 16'(w), w_exp, "t5_word");
      end

      live = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
